image_ram_seq: RTL
==================

// Module: image_ram_seq
// PURPOSE
//  Single-clock sequencer for the dual-port image BRAM (port A write, port B read).
//  Per command, fills an NxN feature map from a valid/ready pixel stream into port A at
//  base_addr, then streams it back from port B in raster order with row/col/last tags.
//  N is selected per command from the five feature-map sizes. Sits between the
//  input/layer-output writer and the convolution datapath.
// PARAMETERS
//  DATA_WIDTH        8   pixel width
//  ADDR_WIDTH        11  BRAM address width
//  FEATURE_MAP1_SIZE 32  N for mode 0
//  FEATURE_MAP2_SIZE 28  N for mode 1
//  FEATURE_MAP3_SIZE 14  N for mode 2
//  FEATURE_MAP4_SIZE 10  N for mode 3
//  FEATURE_MAP5_SIZE 5   N for mode 4
//  RD_LATENCY        2   port-B addrb->doutb latency in cycles (>=1)
// PORTS
//  clk        in  1           system clock; all logic on rising edge
//  rst        in  1           asynchronous, active-high reset
//  start      in  1           command strobe, sampled only in IDLE
//  mode       in  3           size select 0..4; 5..7 invalid
//  load_en    in  1           1: LOAD then READ; 0: READ only (re-read resident map)
//  base_addr  in  ADDR_WIDTH  first BRAM address of the map
//  busy       out 1           high in any state except IDLE
//  done       out 1           1-cycle pulse when last pixel has been output
//  err        out 1           1-cycle pulse: start with invalid mode (command dropped)
//  wr_valid   in  1           loader pixel valid
//  wr_ready   out 1           high only in LOAD
//  wr_data    in  DATA_WIDTH  loader pixel
//  ram_ena    out 1           port A enable
//  ram_wea    out 1           port A write enable
//  ram_addra  out ADDR_WIDTH  port A address
//  ram_dina   out DATA_WIDTH  port A data
//  ram_enb    out 1           port B enable
//  ram_addrb  out ADDR_WIDTH  port B address
//  ram_doutb  in  DATA_WIDTH  port B read data
//  out_valid  out 1           output pixel valid (no backpressure)
//  out_data   out DATA_WIDTH  output pixel (= ram_doutb when out_valid)
//  out_row    out 6           row index 0..N-1 of out_data
//  out_col    out 6           col index 0..N-1 of out_data
//  out_last   out 1           high with the final pixel (row=col=N-1)
// BEHAVIOUR
//  Reset: state IDLE; busy,done,err,wr_ready,ram_ena,ram_wea,ram_enb,out_valid,out_last=0;
//   addresses, data, row/col=0; read-tag pipeline cleared. Reset mid-command aborts it,
//   no done; partial BRAM content left as is.
//  FSM IDLE->LOAD->READ->DRAIN->IDLE.
//   IDLE: start & mode<=4: latch N, base_addr, load_en; go LOAD (load_en=1) else READ.
//     start & mode>4: err pulse next cycle, stay IDLE. start outside IDLE ignored.
//   LOAD: wr_ready=1. Each wr_valid&wr_ready cycle: ram_ena=ram_wea=1,
//     ram_addra=base+i, ram_dina=wr_data, i++ (registered, same-edge as handshake).
//     After N*N-th accept go READ; wr_ready low from the following cycle.
//   READ: one read/cycle, ram_enb=1, ram_addrb=base+j, j=0..N*N-1, no gaps; tag
//     (row,col,last) enters RD_LATENCY-deep shift pipe alongside. After last issue: DRAIN.
//   DRAIN: wait until pipe empty; done pulses in the cycle after out_last; then IDLE.
//  Output: out_valid/row/col/last appear exactly RD_LATENCY cycles after the matching
//   ram_addrb; out_data is combinational ram_doutb. Row/col raster, col fastest.
//  Address arithmetic modulo 2^ADDR_WIDTH: base+N*N overflow wraps to 0.
//  First read issues the cycle after the last write: BRAM must be write-first/no conflict,
//   guaranteed since addresses differ in that cycle only if N*N>1 (N>=5 always).
//  Counters 11 bits (N*N max 1024). wr_valid in non-LOAD states is ignored.
//  Command latency: READ-only start -> first out_valid = 1+RD_LATENCY cycles;
//   total READ-only = N*N+RD_LATENCY+1 cycles to done.
// TESTING
//  mode=4,load_en=1,base=0, stream 0..24 continuous -> BRAM[0..24]=0..24; out_data 0..24,
//   out_last on 25th, done 1 cycle later, busy drops next cycle.
//  mode=0,load_en=1, wr_valid toggling 50% -> exactly 1024 writes, no dup/skip; read back
//   in order with row/col 0..31, out_valid gapless for 1024 cycles.
//  mode=3,load_en=0,base=2040 -> ram_addrb 2040..2047 then 0..91 (wrap), done after 100 pixels.
//  start with mode=6 in IDLE -> err one pulse, busy stays 0; start during READ -> ignored.
//  rst asserted mid-LOAD at i=10 -> all outputs 0 immediately; new command after release
//   runs clean, no stale out_valid from old pipe.
//  RD_LATENCY=1 and 3 builds -> out_valid lag from ram_addrb equals parameter.

Source files
------------

// File: rtl/image_ram_seq.sv
// Sequencer for the dual-port image BRAM: loads an NxN map through port A from a
// valid/ready pixel stream, then replays it from port B in raster order with row/col/last tags.
module image_ram_seq #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 11,
    parameter int FEATURE_MAP1_SIZE = 32,
    parameter int FEATURE_MAP2_SIZE = 28,
    parameter int FEATURE_MAP3_SIZE = 14,
    parameter int FEATURE_MAP4_SIZE = 10,
    parameter int FEATURE_MAP5_SIZE = 5,
    parameter int RD_LATENCY        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [5:0]            out_row,
    output logic [5:0]            out_col,
    output logic                  out_last,
    output logic [1:0]            dbg_state
);

    localparam int CW = 11;
    localparam logic [5:0] N0 = 6'(FEATURE_MAP1_SIZE);
    localparam logic [5:0] N1 = 6'(FEATURE_MAP2_SIZE);
    localparam logic [5:0] N2 = 6'(FEATURE_MAP3_SIZE);
    localparam logic [5:0] N3 = 6'(FEATURE_MAP4_SIZE);
    localparam logic [5:0] N4 = 6'(FEATURE_MAP5_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN} state_t;

    state_t                r_state, w_next;
    logic [5:0]            r_n, r_row, r_col;
    logic [CW-1:0]         r_nn, r_cnt;
    logic [ADDR_WIDTH-1:0] r_base, r_addra;
    logic [DATA_WIDTH-1:0] r_dina;
    logic                  r_ena, r_done, r_err;

    logic                  r_pv   [RD_LATENCY];
    logic                  r_plast[RD_LATENCY];
    logic [5:0]            r_prow [RD_LATENCY];
    logic [5:0]            r_pcol [RD_LATENCY];

    logic [5:0]            w_sel_n;
    logic [CW-1:0]         w_sel_nn;
    logic                  w_mode_ok, w_start_ok, w_accept, w_issue, w_cnt_last;

    always_comb begin
        w_sel_n = N0;
        case (mode)
            3'd1:    w_sel_n = N1;
            3'd2:    w_sel_n = N2;
            3'd3:    w_sel_n = N3;
            3'd4:    w_sel_n = N4;
            default: w_sel_n = N0;
        endcase
    end

    assign w_sel_nn   = CW'(w_sel_n) * CW'(w_sel_n);
    assign w_mode_ok  = (mode <= 3'd4);
    assign w_start_ok = (r_state == S_IDLE) && start && w_mode_ok;
    assign w_accept   = (r_state == S_LOAD) && wr_valid;
    assign w_issue    = (r_state == S_READ);
    assign w_cnt_last = (r_cnt == r_nn - 11'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = load_en ? S_LOAD : S_READ;
            S_LOAD:  if (w_accept && w_cnt_last) w_next = S_READ;
            S_READ:  if (w_cnt_last) w_next = S_DRAIN;
            S_DRAIN: if (r_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n     <= '0;
            r_nn    <= '0;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_base  <= '0;
            r_addra <= '0;
            r_dina  <= '0;
            r_ena   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err  <= (r_state == S_IDLE) && start && !w_mode_ok;
            r_done <= (r_state == S_DRAIN) && out_last;
            r_ena  <= w_accept;
            if (w_accept) begin
                r_addra <= r_base + ADDR_WIDTH'(r_cnt);
                r_dina  <= wr_data;
            end
            if (w_start_ok) begin
                r_n    <= w_sel_n;
                r_nn   <= w_sel_nn;
                r_base <= base_addr;
                r_cnt  <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_accept) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 11'd1;
            end else if (w_issue) begin
                r_cnt <= r_cnt + 11'd1;
                if (r_col == r_n - 6'd1) begin
                    r_col <= '0;
                    r_row <= r_row + 6'd1;
                end else begin
                    r_col <= r_col + 6'd1;
                end
            end
        end
    end

    // Tag pipe mirrors the BRAM read latency so tags line up with ram_doutb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_pv[k]    <= 1'b0;
                r_plast[k] <= 1'b0;
                r_prow[k]  <= '0;
                r_pcol[k]  <= '0;
            end
        end else begin
            r_pv[0]    <= w_issue;
            r_plast[0] <= w_issue && w_cnt_last;
            r_prow[0]  <= w_issue ? r_row : '0;
            r_pcol[0]  <= w_issue ? r_col : '0;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_pv[k]    <= r_pv[k-1];
                r_plast[k] <= r_plast[k-1];
                r_prow[k]  <= r_prow[k-1];
                r_pcol[k]  <= r_pcol[k-1];
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign wr_ready  = (r_state == S_LOAD);
    assign ram_ena   = r_ena;
    assign ram_wea   = r_ena;
    assign ram_addra = r_addra;
    assign ram_dina  = r_dina;
    assign ram_enb   = w_issue;
    assign ram_addrb = w_issue ? (r_base + ADDR_WIDTH'(r_cnt)) : '0;
    assign out_valid = r_pv[RD_LATENCY-1];
    assign out_last  = r_plast[RD_LATENCY-1];
    assign out_row   = r_prow[RD_LATENCY-1];
    assign out_col   = r_pcol[RD_LATENCY-1];
    assign out_data  = out_valid ? ram_doutb : '0;
    assign dbg_state = r_state;

endmodule
